// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single write port of an 8-bit, 8-entry
// register file between ALU writeback (port 0) and load writeback (port 1)
// using valid/ready handshakes and round-robin arbitration. It also runs an
// init sweep that writes zero to every register.
//
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   InitStart               one-cycle request to zero all registers (IDLE only)
//   ReqValid[1:0]           per-port write request
//   ReqAddr0/1, ReqData0/1  per-port destination register and write data
//   ReqReady[1:0]           per-port accept, combinational one-hot grant
//   WriteEn, Waddr, DataIn  registered drive of the register file write port
//   InitDone                registered pulse alongside the last sweep write
//   Busy                    combinational, high while the sweep is running
module rf_write_arbiter #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         InitStart,
  input  logic [1:0]   ReqValid,
  input  logic [D-1:0] ReqAddr0,
  input  logic [D-1:0] ReqAddr1,
  input  logic [W-1:0] ReqData0,
  input  logic [W-1:0] ReqData1,
  output logic [1:0]   ReqReady,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic         InitDone,
  output logic         Busy
);

  localparam int unsigned CNT_W = D + 1;
  localparam int unsigned LAST  = (1 << D) - 1;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               we_q, we_d;
  logic [D-1:0]       waddr_q, waddr_d;
  logic [W-1:0]       data_q, data_d;
  logic               init_done_q, init_done_d;

  logic               grant_vld;
  logic               gnt_port;

  // Grant: only in IDLE and never in a cycle where an init request is pending.
  always_comb begin
    grant_vld = 1'b0;
    gnt_port  = 1'b0;
    if ((state_q == IDLE) && !InitStart && (ReqValid != 2'b00)) begin
      grant_vld = 1'b1;
      if (ReqValid == 2'b11) begin
        gnt_port = rr_ptr_q;
      end else begin
        gnt_port = ReqValid[1];
      end
    end
  end

  always_comb begin
    ReqReady = 2'b00;
    if (grant_vld) begin
      ReqReady = gnt_port ? 2'b10 : 2'b01;
    end
  end

  assign Busy = (state_q == INIT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    data_d      = data_q;
    init_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (InitStart) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (grant_vld) begin
          we_d    = 1'b1;
          waddr_d = gnt_port ? ReqAddr1 : ReqAddr0;
          data_d  = gnt_port ? ReqData1 : ReqData0;
          // Pointer only moves on contention, so a lone requester does not
          // steal the next turn from the other port.
          if (ReqValid == 2'b11) begin
            rr_ptr_d = ~gnt_port;
          end
        end
      end
      INIT: begin
        we_d    = 1'b1;
        waddr_d = cnt_q[D-1:0];
        data_d  = '0;
        cnt_d   = cnt_q + CNT_W'(1);
        // Terminal compare: the edge issuing the last address ends the sweep.
        if (cnt_q == CNT_W'(LAST)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  assign WriteEn  = we_q;
  assign Waddr    = waddr_q;
  assign DataIn   = data_q;
  assign InitDone = init_done_q;

endmodule
